// File: rtl/addsub_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : addsub_accumulator
// Purpose  : Sequential add/subtract accumulator stage. Accepts one command
//            (CLR / LOAD / ADD / SUB) with an operand over a valid/ready
//            handshake, applies it to a running accumulator, and presents the
//            registered result with carry, signed-overflow, zero and negative
//            flags over a second valid/ready handshake.
// Ports    : clk        rising-edge clock
//            rst_n      asynchronous active-low reset
//            in_valid   command/operand present
//            in_ready   block can accept a command
//            cmd        00 CLR, 01 LOAD, 10 ADD, 11 SUB
//            operand    operand b [WIDTH-1:0]
//            out_valid  result/flags valid
//            out_ready  downstream accepts result
//            acc        accumulator value [WIDTH-1:0]
//            carry      carry-out of last ADD/SUB (SUB: 1 = no borrow)
//            ovf        two's-complement overflow of last ADD/SUB
//            zero       acc == 0
//            neg        acc sign bit
// Revision : 1.0  initial release
// ============================================================================
module addsub_accumulator #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       cmd,
    input  logic [WIDTH-1:0] operand,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] acc,
    output logic             carry,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam logic [1:0] c_CMD_CLR  = 2'b00;
    localparam logic [1:0] c_CMD_LOAD = 2'b01;
    localparam logic [1:0] c_CMD_ADD  = 2'b10;
    localparam logic [1:0] c_CMD_SUB  = 2'b11;

    typedef enum logic [1:0] {
        c_IDLE = 2'd0,
        c_EXEC = 2'd1,
        c_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [1:0]         r_cmd;
    logic [WIDTH-1:0]   r_operand;
    logic [WIDTH-1:0]   r_acc;
    logic               r_carry;
    logic               r_ovf;
    logic               r_zero;
    logic               r_neg;
    logic               r_in_ready;
    logic               r_out_valid;

    logic               w_sub;
    logic [WIDTH-1:0]   w_b_eff;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_new_acc;
    logic               w_new_carry;
    logic               w_new_ovf;

    // Subtraction is addition of the one's complement plus a carry-in of 1,
    // so a carry-out of 1 on SUB means "no borrow".
    assign w_sub   = (r_cmd == c_CMD_SUB);
    assign w_b_eff = r_operand ^ {WIDTH{w_sub}};
    assign w_sum   = {1'b0, r_acc} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_sub};

    always_comb begin
        w_new_acc   = '0;
        w_new_carry = 1'b0;
        w_new_ovf   = 1'b0;
        case (r_cmd)
            c_CMD_CLR: begin
                w_new_acc = '0;
            end
            c_CMD_LOAD: begin
                w_new_acc = r_operand;
            end
            c_CMD_ADD, c_CMD_SUB: begin
                w_new_acc   = w_sum[WIDTH-1:0];
                w_new_carry = w_sum[WIDTH];
                // Overflow: both addends share a sign and the result's sign differs.
                w_new_ovf   = (r_acc[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                              (w_sum[WIDTH-1] != r_acc[WIDTH-1]);
            end
            default: begin
                w_new_acc = '0;
            end
        endcase
    end

    // in_ready is registered: it comes up one edge after reset release and
    // is raised on the same edge that returns the FSM to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_cmd       <= c_CMD_CLR;
            r_operand   <= '0;
            r_acc       <= '0;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b1;
            r_neg       <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (in_valid && r_in_ready) begin
                        r_cmd      <= cmd;
                        r_operand  <= operand;
                        r_in_ready <= 1'b0;
                        r_state    <= c_EXEC;
                    end
                end
                c_EXEC: begin
                    r_acc       <= w_new_acc;
                    r_carry     <= w_new_carry;
                    r_ovf       <= w_new_ovf;
                    r_zero      <= (w_new_acc == '0);
                    r_neg       <= w_new_acc[WIDTH-1];
                    r_out_valid <= 1'b1;
                    r_state     <= c_DONE;
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= c_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b0;
                    r_state     <= c_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign acc       = r_acc;
    assign carry     = r_carry;
    assign ovf       = r_ovf;
    assign zero      = r_zero;
    assign neg       = r_neg;

endmodule
`default_nettype wire

// File: tb/tb_addsub_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_addsub_accumulator
// Purpose  : Directed self-checking bench for addsub_accumulator (WIDTH=4).
// Revision : 1.0  initial release
// ============================================================================
module tb_addsub_accumulator;

    localparam int WIDTH = 4;
    localparam logic [1:0] c_CLR  = 2'b00;
    localparam logic [1:0] c_LOAD = 2'b01;
    localparam logic [1:0] c_ADD  = 2'b10;
    localparam logic [1:0] c_SUB  = 2'b11;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       cmd;
    logic [WIDTH-1:0] operand;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic             ovf;
    logic             zero;
    logic             neg;

    int n_cmp;
    int n_fail;

    addsub_accumulator #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cmd       (cmd),
        .operand   (operand),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc       (acc),
        .carry     (carry),
        .ovf       (ovf),
        .zero      (zero),
        .neg       (neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one command from a negedge; returns at the negedge after the
    // EXEC edge, with the result held in DONE. Checks the one-cycle latency.
    task automatic run_cmd(input logic [1:0] c, input logic [WIDTH-1:0] op, input string name);
        int waited;
        waited = 0;
        while (in_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s in_ready timeout: got %b required 1", name, in_ready);
        end
        in_valid = 1'b1;
        cmd      = c;
        operand  = op;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s early out_valid: got %b required 0", name, out_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s latency out_valid: got %b required 1", name, out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        cmd       = c_CLR;
        operand   = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({acc, carry, ovf, zero, neg, out_valid, in_ready} !== {4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: got acc=%h c=%b v=%b z=%b n=%b ov=%b ir=%b required acc=0 c=0 v=0 z=1 n=0 ov=0 ir=0",
                     acc, carry, ovf, zero, neg, out_valid, in_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || acc !== 4'h0 || zero !== 1'b1) begin
            n_fail++;
            $display("FAIL after_release: got ir=%b ov=%b acc=%h z=%b required ir=1 ov=0 acc=0 z=1",
                     in_ready, out_valid, acc, zero);
        end
    endtask

    task automatic test_sub_overflow();
        run_cmd(c_LOAD, 4'd8, "load8");
        n_cmp++;
        if ({acc, carry, ovf, zero, neg} !== {4'h8, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL load8: got acc=%h c=%b v=%b z=%b n=%b required acc=8 c=0 v=0 z=0 n=1", acc, carry, ovf, zero, neg);
        end
        run_cmd(c_SUB, 4'd3, "sub3");
        n_cmp++;
        if ({acc, carry, ovf, zero, neg} !== {4'h5, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL sub_8_3: got acc=%h c=%b v=%b z=%b n=%b required acc=5 c=1 v=1 z=0 n=0", acc, carry, ovf, zero, neg);
        end
    endtask

    task automatic test_sub_zero();
        run_cmd(c_LOAD, 4'd2, "load2");
        run_cmd(c_SUB, 4'd2, "sub2");
        n_cmp++;
        if ({acc, carry, ovf, zero, neg} !== {4'h0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL sub_2_2: got acc=%h c=%b v=%b z=%b n=%b required acc=0 c=1 v=0 z=1 n=0", acc, carry, ovf, zero, neg);
        end
    endtask

    task automatic test_sub_borrow();
        run_cmd(c_LOAD, 4'd5, "load5");
        run_cmd(c_SUB, 4'd6, "sub6");
        n_cmp++;
        if ({acc, carry, ovf, zero, neg} !== {4'hF, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL sub_5_6: got acc=%h c=%b v=%b z=%b n=%b required acc=f c=0 v=0 z=0 n=1", acc, carry, ovf, zero, neg);
        end
    endtask

    task automatic test_add_wrap();
        run_cmd(c_LOAD, 4'd7, "load7");
        run_cmd(c_ADD, 4'd4, "add4");
        n_cmp++;
        if ({acc, carry, ovf, zero, neg} !== {4'hB, 1'b0, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL add_7_4: got acc=%h c=%b v=%b z=%b n=%b required acc=b c=0 v=1 z=0 n=1", acc, carry, ovf, zero, neg);
        end
        run_cmd(c_ADD, 4'd5, "add5");
        n_cmp++;
        if ({acc, carry, ovf, zero, neg} !== {4'h0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL add_b_5: got acc=%h c=%b v=%b z=%b n=%b required acc=0 c=1 v=0 z=1 n=0", acc, carry, ovf, zero, neg);
        end
    endtask

    task automatic test_clr();
        run_cmd(c_LOAD, 4'd9, "load9");
        run_cmd(c_ADD, 4'd9, "add9");
        n_cmp++;
        if ({acc, carry, ovf, zero, neg} !== {4'h2, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL add_9_9: got acc=%h c=%b v=%b z=%b n=%b required acc=2 c=1 v=1 z=0 n=0", acc, carry, ovf, zero, neg);
        end
        run_cmd(c_CLR, 4'd6, "clr");
        n_cmp++;
        if ({acc, carry, ovf, zero, neg} !== {4'h0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL clr: got acc=%h c=%b v=%b z=%b n=%b required acc=0 c=0 v=0 z=1 n=0", acc, carry, ovf, zero, neg);
        end
    endtask

    task automatic test_backpressure();
        run_cmd(c_LOAD, 4'd3, "load3");
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            cmd      = c_ADD;
            operand  = 4'd1;
            @(negedge clk);
            n_cmp++;
            if ({acc, carry, ovf, zero, neg, out_valid, in_ready} !== {4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL backpressure_%0d: got acc=%h c=%b v=%b z=%b n=%b ov=%b ir=%b required acc=3 c=0 v=0 z=0 n=0 ov=1 ir=0",
                         i, acc, carry, ovf, zero, neg, out_valid, in_ready);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || acc !== 4'h3) begin
            n_fail++;
            $display("FAIL release_backpressure: got ov=%b ir=%b acc=%h required ov=0 ir=1 acc=3", out_valid, in_ready, acc);
        end
        // Accept ADD 1, then hit reset while the command sits in EXEC.
        in_valid = 1'b1;
        cmd      = c_ADD;
        operand  = 4'd1;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        n_cmp++;
        if ({acc, carry, ovf, zero, neg, out_valid, in_ready} !== {4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid_exec: got acc=%h c=%b v=%b z=%b n=%b ov=%b ir=%b required acc=0 c=0 v=0 z=1 n=0 ov=0 ir=0",
                     acc, carry, ovf, zero, neg, out_valid, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || acc !== 4'h0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL no_replay: got ov=%b acc=%h ir=%b required ov=0 acc=0 ir=1", out_valid, acc, in_ready);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_sub_overflow();
        test_sub_zero();
        test_sub_borrow();
        test_add_wrap();
        test_clr();
        test_backpressure();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
